// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared operand width, loader state encoding and saturation limits
package mult_pkg;

  localparam int OPERAND_W = 8;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Two's-complement extremes for an OPERAND_W-bit operand.
  localparam logic [OPERAND_W-1:0] SAT_POS = 8'h7F;
  localparam logic [OPERAND_W-1:0] SAT_NEG = 8'h80;

endpackage

// File: rtl/sm_to_twos.sv
// rtl/sm_to_twos.sv - sign-magnitude to two's-complement converter with range check
// Out-of-range handling: SM_LOADER_SATURATE_EN defined = saturate, undefined = wrap.
module sm_to_twos
  import mult_pkg::*;
#(
  parameter int WIDTH = OPERAND_W
) (
  input  logic             sign_i,
  input  logic [WIDTH-1:0] magnitude_i,
  output logic [WIDTH-1:0] value_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] POS_LIM = (WIDTH == OPERAND_W) ? WIDTH'(SAT_POS)
                                                              : {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_LIM = (WIDTH == OPERAND_W) ? WIDTH'(SAT_NEG)
                                                              : {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] neg_val;
  logic             pos_err;
  logic             neg_err;

  // Negative zero falls out naturally: ~0 + 1 truncates to 0.
  assign neg_val = ~magnitude_i + WIDTH'(1);
  assign pos_err = magnitude_i[WIDTH-1];
  // -2^(N-1) is representable, so only magnitudes strictly above it fail.
  assign neg_err = magnitude_i[WIDTH-1] & (|magnitude_i[WIDTH-2:0]);
  assign err_o   = sign_i ? neg_err : pos_err;

`ifdef SM_LOADER_SATURATE_EN
  always_comb begin
    value_o = sign_i ? neg_val : magnitude_i;
    if (err_o) begin
      value_o = sign_i ? NEG_LIM : POS_LIM;
    end
  end
`else
  assign value_o = sign_i ? neg_val : magnitude_i;
`endif

endmodule

// File: rtl/sm_operand_loader.sv
// rtl/sm_operand_loader.sv - captures sign-magnitude operands A then B and holds the converted pair
// Saturating conversion when SM_LOADER_SATURATE_EN is defined; wrapping otherwise.
module sm_operand_loader
  import mult_pkg::*;
#(
  parameter int WIDTH = OPERAND_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_sign,
  input  logic [WIDTH-1:0] in_magnitude,
  output logic             in_ready,
  output logic             in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_range_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;

  logic [WIDTH-1:0] conv_value;
  logic             conv_err;
  logic             in_fire;
  logic             out_fire;

  // One converter serves both operands: at most one is captured per cycle.
  sm_to_twos #(
    .WIDTH (WIDTH)
  ) u_conv (
    .sign_i      (in_sign),
    .magnitude_i (in_magnitude),
    .value_o     (conv_value),
    .err_o       (conv_err)
  );

  assign in_ready  = (state_q != HOLD);
  assign in_sel    = (state_q == WAIT_B);
  assign out_valid = (state_q == HOLD);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    err_d   = err_q;
    pend_d  = pend_q;

    if (clear) begin
      state_d = WAIT_A;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_A: begin
          if (in_fire) begin
            out_a_d = conv_value;
            pend_d  = conv_err;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (in_fire) begin
            out_b_d = conv_value;
            err_d   = pend_q | conv_err;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_fire) begin
            state_d = WAIT_A;
          end
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_A;
      out_a_q <= '0;
      out_b_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign out_a         = out_a_q;
  assign out_b         = out_b_q;
  assign out_range_err = err_q;

endmodule

// File: tb/tb_sm_operand_loader.sv
// tb/tb_sm_operand_loader.sv - scoreboard bench for sm_operand_loader
module tb_sm_operand_loader;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       err;
  } pair_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sign = 1'b0;
  logic [7:0] in_magnitude = 8'h00;
  logic       in_ready;
  logic       in_sel;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic       out_range_err;

  int    checks = 0;
  int    failures = 0;
  pair_t sb[$];

  always #5 clk = ~clk;

  sm_operand_loader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_sign       (in_sign),
    .in_magnitude  (in_magnitude),
    .in_ready      (in_ready),
    .in_sel        (in_sel),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_range_err (out_range_err)
  );

  function automatic logic [8:0] model(input logic s, input logic [7:0] m);
    int         v;
    logic       e;
    logic [7:0] r;
    v = s ? -int'(m) : int'(m);
    e = (v > 127) || (v < -128);
    r = 8'(v);
`ifdef SM_LOADER_SATURATE_EN
    if (v > 127) r = 8'h7F;
    else if (v < -128) r = 8'h80;
`endif
    return {r, e};
  endfunction

  task automatic push_model(input logic sa, input logic [7:0] ma,
                            input logic sb_s, input logic [7:0] mb);
    pair_t p;
    logic [8:0] ra, rb;
    ra = model(sa, ma);
    rb = model(sb_s, mb);
    p.a = ra[8:1];
    p.b = rb[8:1];
    p.err = ra[0] | rb[0];
    sb.push_back(p);
  endtask

  task automatic push_const(input logic [7:0] a, input logic [7:0] b, input logic e);
    pair_t p;
    p.a = a;
    p.b = b;
    p.err = e;
    sb.push_back(p);
  endtask

  // Called #1 after a rising edge; returns #1 after the capturing edge.
  task automatic send_op(input logic s, input logic [7:0] m, input logic exp_sel);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_in_ready_timeout actual=%b required=1", in_ready);
    end
    checks++;
    if (in_sel !== exp_sel) begin
      failures++;
      $display("FAIL in_sel actual=%b required=%b", in_sel, exp_sel);
    end
    in_valid = 1'b1;
    in_sign = s;
    in_magnitude = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic sa, input logic [7:0] ma,
                           input logic sb_s, input logic [7:0] mb);
    send_op(sa, ma, 1'b0);
    send_op(sb_s, mb, 1'b1);
  endtask

  task automatic consume(input string name);
    int    n;
    pair_t p;
    n = 0;
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      failures++;
      $display("FAIL %s_out_valid_timeout actual=%b required=1 queued=%0d", name, out_valid, sb.size());
      out_ready = 1'b0;
      return;
    end
    p = sb.pop_front();
    checks++;
    if (out_a !== p.a) begin
      failures++;
      $display("FAIL %s_out_a actual=%h required=%h", name, out_a, p.a);
    end
    checks++;
    if (out_b !== p.b) begin
      failures++;
      $display("FAIL %s_out_b actual=%h required=%h", name, out_b, p.b);
    end
    checks++;
    if (out_range_err !== p.err) begin
      failures++;
      $display("FAIL %s_range_err actual=%b required=%b", name, out_range_err, p.err);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || in_sel !== 1'b0) begin
      failures++;
      $display("FAIL %s_release actual=v%b r%b s%b required=v0 r1 s0", name, out_valid, in_ready, in_sel);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (in_ready !== 1'b1 || in_sel !== 1'b0 || out_valid !== 1'b0 ||
        out_a !== 8'h00 || out_b !== 8'h00 || out_range_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values actual=r%b s%b v%b a%h b%h e%b required=r1 s0 v0 a00 b00 e0",
               in_ready, in_sel, out_valid, out_a, out_b, out_range_err);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    push_const(8'h05, 8'hFD, 1'b0);
    send_pair(1'b0, 8'd5, 1'b1, 8'd3);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency actual=%b required=1", out_valid);
    end
    consume("basic");
  endtask

  task automatic test_boundaries;
    push_const(8'h80, 8'h00, 1'b0);
    send_pair(1'b1, 8'd128, 1'b1, 8'd0);
    consume("neg_min_negzero");
`ifdef SM_LOADER_SATURATE_EN
    push_const(8'h7F, 8'h80, 1'b1);
`else
    push_const(8'h80, 8'h38, 1'b1);
`endif
    send_pair(1'b0, 8'd128, 1'b1, 8'd200);
    consume("out_of_range");
    push_const(8'h7F, 8'h81, 1'b0);
    send_pair(1'b0, 8'd127, 1'b1, 8'd127);
    consume("in_range_edges");
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    push_const(8'hF9, 8'h0C, 1'b0);
    send_pair(1'b1, 8'd7, 1'b0, 8'd12);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_sign = ~i[1];
      in_magnitude = 8'(8'd30 + i);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_a !== 8'hF9 ||
          out_b !== 8'h0C || out_range_err !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable_%0d actual=v%b r%b a%h b%h e%b required=v1 r0 aF9 b0C e0",
                 i, out_valid, in_ready, out_a, out_b, out_range_err);
      end
    end
    in_valid = 1'b0;
    consume("hold");
  endtask

  task automatic test_clear;
    send_op(1'b0, 8'd200, 1'b0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (in_sel !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_state actual=s%b v%b required=s0 v0", in_sel, out_valid);
    end
    push_const(8'h02, 8'h03, 1'b0);
    send_pair(1'b0, 8'd2, 1'b0, 8'd3);
    consume("clear_recover");
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    send_pair(1'b1, 8'd200, 1'b1, 8'd9);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_a !== 8'h00 || out_b !== 8'h00 || out_range_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset actual=v%b a%h b%h e%b required=v0 a00 b00 e0",
               out_valid, out_a, out_b, out_range_err);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || in_sel !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_release actual=r%b s%b required=r1 s0", in_ready, in_sel);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] choices [4];
    logic       sa, sbs;
    logic [7:0] ma, mb;
    choices[0] = 8'd0;
    choices[1] = 8'd127;
    choices[2] = 8'd128;
    choices[3] = 8'd255;
    for (int i = 0; i < 24; i++) begin
      sa = 1'($urandom);
      sbs = 1'($urandom);
      ma = (i % 3 == 0) ? choices[i % 4] : 8'($urandom);
      mb = (i % 5 == 0) ? choices[(i + 1) % 4] : 8'($urandom);
      push_model(sa, ma, sbs, mb);
      send_pair(sa, ma, sbs, mb);
      consume("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_hold();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
